// File: rtl/tree_router_sync.sv
// Tree NoC router node: one parent and NUM_CHILD child valid/ready ports, a FIFO per input,
// and a round-robin arbiter feeding a one-entry output register per output.
module tree_router_sync #(
    parameter int WIDTH_packet = 14,
    parameter int WIDTH_dest   = 3,
    parameter int WIDTH_addr   = 3,
    parameter int WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest,
    parameter int NUM_CHILD    = 2,
    parameter int LEVEL        = 2,
    parameter int PREFIX       = 0,
    parameter int DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           parent_in_data,
    input  logic                       parent_in_valid,
    output logic                       parent_in_ready,
    output logic [WIDTH-1:0]           parent_out_data,
    output logic                       parent_out_valid,
    input  logic                       parent_out_ready,
    input  logic [NUM_CHILD*WIDTH-1:0] child_in_data,
    input  logic [NUM_CHILD-1:0]       child_in_valid,
    output logic [NUM_CHILD-1:0]       child_in_ready,
    output logic [NUM_CHILD*WIDTH-1:0] child_out_data,
    output logic [NUM_CHILD-1:0]       child_out_valid,
    input  logic [NUM_CHILD-1:0]       child_out_ready,
    output logic [7:0]                 drop_count
);

    localparam int NP = NUM_CHILD + 1;
    localparam int CB = $clog2(NUM_CHILD);
    localparam int PW = $clog2(NP);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]           FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [WIDTH_dest-1:0] PREFIX_V = WIDTH_dest'(PREFIX);

    function automatic logic [PW-1:0] route_target(input logic [WIDTH_dest-1:0] dest);
        logic [CB-1:0] sel;
        sel = CB'(dest >> (LEVEL - CB));
        // At the root LEVEL == WIDTH_dest, so both shifts give zero and every dest is owned.
        if ((dest >> LEVEL) == (PREFIX_V >> LEVEL))
            return PW'(sel) + PW'(1);
        return '0;
    endfunction

    logic [WIDTH-1:0] w_in_data [NP];
    logic [NP-1:0]    w_in_valid, w_out_ready;
    logic [NP-1:0]    w_full, w_empty, w_push, w_pop, w_drop, w_load, w_any;
    logic [WIDTH-1:0] w_head [NP];
    logic [PW-1:0]    w_target [NP];
    logic [PW-1:0]    w_win [NP];
    logic [NP-1:0]    w_gnt [NP];
    logic [8:0]       w_drop_sum;

    logic [WIDTH-1:0] r_mem [NP][DEPTH];
    logic [AW-1:0]    r_wptr [NP];
    logic [AW-1:0]    r_rptr [NP];
    logic [AW:0]      r_count [NP];
    logic [WIDTH-1:0] r_out_data [NP];
    logic [NP-1:0]    r_out_valid;
    logic [PW-1:0]    r_rr [NP];
    logic [7:0]       r_drop_count;

    assign w_in_data[0]    = parent_in_data;
    assign w_in_valid[0]   = parent_in_valid;
    assign w_out_ready[0]  = parent_out_ready;
    assign parent_in_ready = ~w_full[0];
    assign parent_out_data = r_out_data[0];
    assign parent_out_valid = r_out_valid[0];
    assign drop_count      = r_drop_count;

    for (genvar c = 0; c < NUM_CHILD; c++) begin : g_child
        assign w_in_data[c+1]                     = child_in_data[c*WIDTH +: WIDTH];
        assign w_in_valid[c+1]                    = child_in_valid[c];
        assign w_out_ready[c+1]                   = child_out_ready[c];
        assign child_in_ready[c]                  = ~w_full[c+1];
        assign child_out_data[c*WIDTH +: WIDTH]   = r_out_data[c+1];
        assign child_out_valid[c]                 = r_out_valid[c+1];
    end

    always_comb begin : p_fifo_status
        for (int p = 0; p < NP; p++) begin
            w_full[p]   = (r_count[p] == FULL_CNT);
            w_empty[p]  = (r_count[p] == '0);
            w_push[p]   = w_in_valid[p] && !w_full[p];
            w_head[p]   = r_mem[p][r_rptr[p]];
            w_target[p] = route_target(w_head[p][WIDTH-1 -: WIDTH_dest]);
            w_drop[p]   = !w_empty[p] && (w_target[p] == PW'(p));
        end
    end

    always_comb begin : p_arb
        int idx;
        idx   = 0;
        w_pop = w_drop;
        for (int o = 0; o < NP; o++) begin
            w_any[o]  = 1'b0;
            w_win[o]  = '0;
            w_gnt[o]  = '0;
            w_load[o] = !r_out_valid[o] || w_out_ready[o];
            // Scan inputs starting at the round-robin pointer; first requester wins.
            for (int k = 0; k < NP; k++) begin
                idx = (int'(r_rr[o]) + k) % NP;
                if (!w_any[o] && !w_empty[idx] && (w_target[idx] == PW'(o)) && (idx != o)) begin
                    w_any[o] = 1'b1;
                    w_win[o] = PW'(idx);
                end
            end
            if (w_load[o] && w_any[o]) begin
                w_gnt[o][w_win[o]] = 1'b1;
                w_pop[w_win[o]]    = 1'b1;
            end
        end
    end

    always_comb begin : p_drop_sum
        w_drop_sum = {1'b0, r_drop_count} + 9'($countones(w_drop));
    end

    // NOTE: FIFO storage is not reset; r_count gates every read, so stale data is never observed.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++)
            if (w_push[p]) r_mem[p][r_wptr[p]] <= w_in_data[p];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                r_wptr[p]  <= '0;
                r_rptr[p]  <= '0;
                r_count[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (w_push[p]) r_wptr[p] <= r_wptr[p] + AW'(1);
                if (w_pop[p])  r_rptr[p] <= r_rptr[p] + AW'(1);
                case ({w_push[p], w_pop[p]})
                    2'b10:   r_count[p] <= r_count[p] + (AW+1)'(1);
                    2'b01:   r_count[p] <= r_count[p] - (AW+1)'(1);
                    default: r_count[p] <= r_count[p];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= '0;
            r_drop_count <= '0;
            for (int o = 0; o < NP; o++) begin
                r_out_data[o] <= '0;
                r_rr[o]       <= '0;
            end
        end else begin
            r_drop_count <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
            for (int o = 0; o < NP; o++) begin
                if (w_load[o]) begin
                    r_out_valid[o] <= w_any[o];
                    if (w_any[o]) begin
                        r_out_data[o] <= w_head[w_win[o]];
                        r_rr[o]       <= (w_win[o] == PW'(NP-1)) ? '0 : w_win[o] + PW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tree_router_sync.sv
// Directed bench for tree_router_sync: an interior node (LEVEL=2) and a root node (LEVEL=3)
// driven with hand-built flits {dest, addr, payload} and checked against hand-computed results.
module tb_tree_router_sync;

    logic        clk = 1'b0;
    logic        rst;

    logic [19:0] parent_in_data, parent_out_data;
    logic        parent_in_valid, parent_in_ready, parent_out_valid, parent_out_ready;
    logic [39:0] child_in_data, child_out_data;
    logic [1:0]  child_in_valid, child_in_ready, child_out_valid, child_out_ready;
    logic [7:0]  drop_count;

    logic [19:0] rt_parent_in_data, rt_parent_out_data;
    logic        rt_parent_in_valid, rt_parent_in_ready, rt_parent_out_valid, rt_parent_out_ready;
    logic [39:0] rt_child_in_data, rt_child_out_data;
    logic [1:0]  rt_child_in_valid, rt_child_in_ready, rt_child_out_valid, rt_child_out_ready;
    logic [7:0]  rt_drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    tree_router_sync dut (
        .clk(clk), .rst(rst),
        .parent_in_data(parent_in_data), .parent_in_valid(parent_in_valid),
        .parent_in_ready(parent_in_ready), .parent_out_data(parent_out_data),
        .parent_out_valid(parent_out_valid), .parent_out_ready(parent_out_ready),
        .child_in_data(child_in_data), .child_in_valid(child_in_valid),
        .child_in_ready(child_in_ready), .child_out_data(child_out_data),
        .child_out_valid(child_out_valid), .child_out_ready(child_out_ready),
        .drop_count(drop_count)
    );

    tree_router_sync #(.NUM_CHILD(2), .LEVEL(3), .PREFIX(0)) dut_root (
        .clk(clk), .rst(rst),
        .parent_in_data(rt_parent_in_data), .parent_in_valid(rt_parent_in_valid),
        .parent_in_ready(rt_parent_in_ready), .parent_out_data(rt_parent_out_data),
        .parent_out_valid(rt_parent_out_valid), .parent_out_ready(rt_parent_out_ready),
        .child_in_data(rt_child_in_data), .child_in_valid(rt_child_in_valid),
        .child_in_ready(rt_child_in_ready), .child_out_data(rt_child_out_data),
        .child_out_valid(rt_child_out_valid), .child_out_ready(rt_child_out_ready),
        .drop_count(rt_drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic [2:0] d, input logic [2:0] a, input logic [13:0] pl);
        return {d, a, pl};
    endfunction

    function automatic logic [2:0] ov();
        return {child_out_valid, parent_out_valid};
    endfunction

    function automatic logic [19:0] out_d(input int p);
        if (p == 0) return parent_out_data;
        return child_out_data[(p-1)*20 +: 20];
    endfunction

    function automatic logic [2:0] rt_ov();
        return {rt_child_out_valid, rt_parent_out_valid};
    endfunction

    function automatic logic [19:0] rt_out_d(input int p);
        if (p == 0) return rt_parent_out_data;
        return rt_child_out_data[(p-1)*20 +: 20];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int p, input logic [19:0] d, input logic v);
        if (p == 0) begin
            parent_in_data  = d;
            parent_in_valid = v;
        end else begin
            child_in_data[(p-1)*20 +: 20] = d;
            child_in_valid[p-1]           = v;
        end
    endtask

    task automatic rt_set_in(input int p, input logic [19:0] d, input logic v);
        if (p == 0) begin
            rt_parent_in_data  = d;
            rt_parent_in_valid = v;
        end else begin
            rt_child_in_data[(p-1)*20 +: 20] = d;
            rt_child_in_valid[p-1]           = v;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        n_checks++;
        if (ov() !== 3'b000) $display("FAIL reset_out_valid: got %b expected 000", ov());
        else n_pass++;
        n_checks++;
        if (drop_count !== 8'd0) $display("FAIL reset_drop_count: got %0d expected 0", drop_count);
        else n_pass++;
        n_checks++;
        if ({child_in_ready, parent_in_ready} !== 3'b111)
            $display("FAIL reset_in_ready: got %b expected 111", {child_in_ready, parent_in_ready});
        else n_pass++;
        n_checks++;
        if ({child_out_data, parent_out_data} !== 60'd0)
            $display("FAIL reset_out_data: got %h expected 0", {child_out_data, parent_out_data});
        else n_pass++;
        n_checks++;
        if ({rt_child_in_ready, rt_parent_in_ready, rt_ov()} !== 6'b111000)
            $display("FAIL reset_root_status: got %b expected 111000",
                     {rt_child_in_ready, rt_parent_in_ready, rt_ov()});
        else n_pass++;
    endtask

    task automatic basic_case(input int src, input logic [19:0] f, input int exp_port, input string name);
        set_in(src, f, 1'b1);
        tick();
        set_in(src, 20'd0, 1'b0);
        n_checks++;
        if (ov() !== 3'b000) $display("FAIL %s_early: got %b expected 000", name, ov());
        else n_pass++;
        tick();
        n_checks++;
        if (ov() !== (3'b001 << exp_port)) $display("FAIL %s_valid: got %b expected %b", name, ov(), 3'b001 << exp_port);
        else n_pass++;
        n_checks++;
        if (out_d(exp_port) !== f) $display("FAIL %s_data: got %h expected %h", name, out_d(exp_port), f);
        else n_pass++;
        tick();
        n_checks++;
        if (ov() !== 3'b000) $display("FAIL %s_idle: got %b expected 000", name, ov());
        else n_pass++;
    endtask

    task automatic test_basic_routing();
        basic_case(0, mk(3'b001, 3'd5, 14'h1234), 1, "route_p_to_c0");
        basic_case(0, mk(3'b011, 3'd6, 14'h0F0F), 2, "route_p_to_c1");
        basic_case(1, mk(3'b110, 3'd2, 14'h2ABC), 0, "route_c0_to_p");
    endtask

    task automatic test_backpressure();
        logic [19:0] fb [6];
        logic        stable;
        logic        acc;
        for (int i = 0; i < 6; i++) fb[i] = mk(3'b011, 3'd0, 14'h0A0 + 14'(i));
        child_out_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (parent_in_ready !== 1'b1) $display("FAIL bp_ready_before_%0d: got %b expected 1", i, parent_in_ready);
            else n_pass++;
            set_in(0, fb[i], 1'b1);
            tick();
        end
        set_in(0, fb[5], 1'b1);
        n_checks++;
        if (parent_in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b expected 0", parent_in_ready);
        else n_pass++;
        stable = 1'b1;
        repeat (3) begin
            if (child_out_valid[1] !== 1'b1 || out_d(2) !== fb[0] || parent_in_ready !== 1'b0) stable = 1'b0;
            tick();
        end
        n_checks++;
        if (stable !== 1'b1 || out_d(2) !== fb[0])
            $display("FAIL bp_hold: got %h expected %h held", out_d(2), fb[0]);
        else n_pass++;
        child_out_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (child_out_valid[1] !== 1'b1 || out_d(2) !== fb[k])
                $display("FAIL bp_drain_%0d: got %b/%h expected 1/%h", k, child_out_valid[1], out_d(2), fb[k]);
            else n_pass++;
            acc = parent_in_valid && parent_in_ready;
            tick();
            if (acc) set_in(0, 20'd0, 1'b0);
        end
        n_checks++;
        if (child_out_valid[1] !== 1'b0) $display("FAIL bp_drained: got %b expected 0", child_out_valid[1]);
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [19:0] obs [10];
        int n_obs, cyc, pi, ci, alt_err, ord_err, n_par, n_c0, exp_p, exp_c;
        logic acc_p, acc_c;
        pi = 0; ci = 0; n_obs = 0; cyc = 0;
        set_in(0, mk(3'b011, 3'd0, 14'h1000), 1'b1);
        set_in(1, mk(3'b011, 3'd1, 14'h2000), 1'b1);
        while (n_obs < 10 && cyc < 40) begin
            if (child_out_valid[1]) begin
                obs[n_obs] = out_d(2);
                n_obs++;
            end
            acc_p = parent_in_valid && parent_in_ready;
            acc_c = child_in_valid[0] && child_in_ready[0];
            tick();
            cyc++;
            if (acc_p) begin pi++; set_in(0, mk(3'b011, 3'd0, 14'h1000 + 14'(pi)), 1'b1); end
            if (acc_c) begin ci++; set_in(1, mk(3'b011, 3'd1, 14'h2000 + 14'(ci)), 1'b1); end
        end
        set_in(0, 20'd0, 1'b0);
        set_in(1, 20'd0, 1'b0);
        repeat (20) tick();
        n_checks++;
        if (n_obs !== 10) $display("FAIL fair_timeout: got %0d flits expected 10", n_obs);
        else n_pass++;
        alt_err = 0; ord_err = 0; n_par = 0; n_c0 = 0; exp_p = 0; exp_c = 0;
        for (int k = 0; k < n_obs; k++) begin
            if (k > 0 && obs[k][13:12] == obs[k-1][13:12]) alt_err++;
            if (obs[k][13:12] == 2'b01) begin
                if (int'(obs[k][11:0]) != exp_p) ord_err++;
                exp_p++; n_par++;
            end else begin
                if (int'(obs[k][11:0]) != exp_c) ord_err++;
                exp_c++; n_c0++;
            end
        end
        n_checks++;
        if (alt_err !== 0) $display("FAIL fair_alternate: got %0d repeats expected 0", alt_err);
        else n_pass++;
        n_checks++;
        if (n_par !== 5 || n_c0 !== 5) $display("FAIL fair_share: got %0d/%0d expected 5/5", n_par, n_c0);
        else n_pass++;
        n_checks++;
        if (ord_err !== 0) $display("FAIL fair_order: got %0d out of order expected 0", ord_err);
        else n_pass++;
        n_checks++;
        if (ov() !== 3'b000) $display("FAIL fair_drained: got %b expected 000", ov());
        else n_pass++;
    endtask

    task automatic test_uturn();
        logic saw;
        saw = 1'b0;
        set_in(1, mk(3'b000, 3'd1, 14'h0033), 1'b1);
        repeat (3) begin
            if (ov() !== 3'b000) saw = 1'b1;
            tick();
        end
        set_in(1, 20'd0, 1'b0);
        repeat (3) begin
            if (ov() !== 3'b000) saw = 1'b1;
            tick();
        end
        n_checks++;
        if (drop_count !== 8'd3) $display("FAIL uturn_count3: got %0d expected 3", drop_count);
        else n_pass++;
        n_checks++;
        if (saw !== 1'b0) $display("FAIL uturn_no_output: got output expected none");
        else n_pass++;
        set_in(1, mk(3'b000, 3'd1, 14'h0044), 1'b1);
        repeat (300) begin
            if (ov() !== 3'b000) saw = 1'b1;
            tick();
        end
        set_in(1, 20'd0, 1'b0);
        repeat (3) tick();
        n_checks++;
        if (drop_count !== 8'd255) $display("FAIL uturn_saturate: got %0d expected 255", drop_count);
        else n_pass++;
        n_checks++;
        if (saw !== 1'b0) $display("FAIL uturn_no_output_long: got output expected none");
        else n_pass++;
    endtask

    task automatic test_root();
        int          rsrc [4];
        int          rexp [4];
        logic [19:0] rflit [4];
        logic        saw_parent;
        rsrc  = '{2, 1, 0, 0};
        rexp  = '{1, 2, 2, 1};
        rflit = '{mk(3'b010, 3'd2, 14'h1357), mk(3'b110, 3'd1, 14'h2468),
                  mk(3'b111, 3'd0, 14'h3FFF), mk(3'b001, 3'd7, 14'h0001)};
        saw_parent = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rt_set_in(rsrc[i], rflit[i], 1'b1);
            tick();
            rt_set_in(rsrc[i], 20'd0, 1'b0);
            if (rt_parent_out_valid !== 1'b0) saw_parent = 1'b1;
            tick();
            n_checks++;
            if (rt_ov() !== (3'b001 << rexp[i]) || rt_out_d(rexp[i]) !== rflit[i])
                $display("FAIL root_route_%0d: got %b/%h expected %b/%h", i, rt_ov(), rt_out_d(rexp[i]),
                         3'b001 << rexp[i], rflit[i]);
            else n_pass++;
            if (rt_parent_out_valid !== 1'b0) saw_parent = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_parent !== 1'b0) $display("FAIL root_no_parent: got parent_out_valid expected never");
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic saw;
        child_out_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            set_in(0, mk(3'b011, 3'd0, 14'h0500 + 14'(i)), 1'b1);
            tick();
        end
        set_in(0, 20'd0, 1'b0);
        n_checks++;
        if (child_out_valid[1] !== 1'b1) $display("FAIL rstmid_pre_valid: got %b expected 1", child_out_valid[1]);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (ov() !== 3'b000 || drop_count !== 8'd0)
            $display("FAIL rstmid_async: got %b/%0d expected 000/0", ov(), drop_count);
        else n_pass++;
        @(negedge clk) rst = 1'b0;
        tick();
        n_checks++;
        if ({child_in_ready, parent_in_ready} !== 3'b111 || {child_out_data, parent_out_data} !== 60'd0)
            $display("FAIL rstmid_after: got %b/%h expected 111/0", {child_in_ready, parent_in_ready},
                     {child_out_data, parent_out_data});
        else n_pass++;
        child_out_ready = 2'b11;
        saw = 1'b0;
        repeat (6) begin
            if (ov() !== 3'b000) saw = 1'b1;
            tick();
        end
        n_checks++;
        if (saw !== 1'b0) $display("FAIL rstmid_flushed: got stale output expected none");
        else n_pass++;
    endtask

    initial begin
        parent_in_data = '0; parent_in_valid = 1'b0; parent_out_ready = 1'b1;
        child_in_data = '0; child_in_valid = '0; child_out_ready = 2'b11;
        rt_parent_in_data = '0; rt_parent_in_valid = 1'b0; rt_parent_out_ready = 1'b1;
        rt_child_in_data = '0; rt_child_in_valid = '0; rt_child_out_ready = 2'b11;
        test_reset();
        test_basic_routing();
        test_backpressure();
        test_fairness();
        test_uturn();
        test_root();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
